// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: one-hot T1..T6 ring counter plus opcode decode that
// produces every bus-driver, load and ALU strobe for the SAP_U datapath.
module sap_control_sequencer #(
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] OP_LDA = 4'h0,
  parameter logic [OPW-1:0] OP_ADD = 4'h1,
  parameter logic [OPW-1:0] OP_SUB = 4'h2,
  parameter logic [OPW-1:0] OP_OUT = 4'hE,
  parameter logic [OPW-1:0] OP_HLT = 4'hF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic           step,
  input  logic [OPW-1:0] opcode,
  output logic           pc_enable,
  output logic           pc_inc,
  output logic           mar_load,
  output logic           ram_enable,
  output logic           ir_load,
  output logic           ir_enable,
  output logic           reg_a_load,
  output logic           reg_a_enable,
  output logic           reg_b_load,
  output logic           alu_enable,
  output logic           alu_subtract,
  output logic           out_load,
  output logic [5:0]     t_state,
  output logic           instr_done,
  output logic           halted
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] t_state_q, t_state_d;
  logic       halted_q, halted_d;
  logic       instr_done_q, instr_done_d;
  logic       adv_s;

  // Reset is folded in so no strobe can leak out while the sequencer is held.
  assign adv_s = (run | step) & ~halted_q & reset;

  assign t_state    = t_state_q;
  assign halted     = halted_q;
  assign instr_done = instr_done_q;

  // Next-state: rotate on advance, freeze at T4 when HLT is decoded.
  always_comb begin
    t_state_d    = t_state_q;
    halted_d     = halted_q;
    instr_done_d = 1'b0;
    if (!$onehot(t_state_q)) begin
      // Corrupted ring (e.g. upset) recovers to a clean fetch.
      t_state_d = T1;
    end else if (adv_s) begin
      if ((t_state_q == T4) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else begin
        t_state_d = {t_state_q[4:0], t_state_q[5]};
      end
      instr_done_d = t_state_q[5];
    end else begin
      t_state_d = t_state_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_state_q    <= T1;
      halted_q     <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      t_state_q    <= t_state_d;
      halted_q     <= halted_d;
      instr_done_q <= instr_done_d;
    end
  end

  // Control word decode for the current T-state, silent whenever not advancing.
  always_comb begin
    pc_enable    = 1'b0;
    pc_inc       = 1'b0;
    mar_load     = 1'b0;
    ram_enable   = 1'b0;
    ir_load      = 1'b0;
    ir_enable    = 1'b0;
    reg_a_load   = 1'b0;
    reg_a_enable = 1'b0;
    reg_b_load   = 1'b0;
    alu_enable   = 1'b0;
    alu_subtract = 1'b0;
    out_load     = 1'b0;
    if (adv_s) begin
      case (t_state_q)
        T1: begin
          pc_enable = 1'b1;
          mar_load  = 1'b1;
        end
        T2: begin
          pc_inc = 1'b1;
        end
        T3: begin
          ram_enable = 1'b1;
          ir_load    = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_enable = 1'b1;
              mar_load  = 1'b1;
            end
            OP_OUT: begin
              reg_a_enable = 1'b1;
              out_load     = 1'b1;
            end
            default: begin
            end
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ram_enable = 1'b1;
              reg_a_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_enable = 1'b1;
              reg_b_load = 1'b1;
            end
            default: begin
            end
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              alu_enable = 1'b1;
              reg_a_load = 1'b1;
            end
            OP_SUB: begin
              alu_enable   = 1'b1;
              reg_a_load   = 1'b1;
              alu_subtract = 1'b1;
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end else begin
      pc_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: a step-index reference model
// queues the expected outputs per cycle; a negedge monitor pops and compares.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step;
  logic [3:0] opcode;
  logic       pc_enable, pc_inc, mar_load, ram_enable, ir_load, ir_enable;
  logic       reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract, out_load;
  logic [5:0] t_state;
  logic       instr_done, halted;

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .pc_enable(pc_enable), .pc_inc(pc_inc), .mar_load(mar_load),
    .ram_enable(ram_enable), .ir_load(ir_load), .ir_enable(ir_enable),
    .reg_a_load(reg_a_load), .reg_a_enable(reg_a_enable), .reg_b_load(reg_b_load),
    .alu_enable(alu_enable), .alu_subtract(alu_subtract), .out_load(out_load),
    .t_state(t_state), .instr_done(instr_done), .halted(halted)
  );

  localparam logic [11:0] PCE  = 12'h800, PCI  = 12'h400, MARL = 12'h200;
  localparam logic [11:0] RAME = 12'h100, IRL  = 12'h080, IRE  = 12'h040;
  localparam logic [11:0] RAL  = 12'h020, RAE  = 12'h010, RBL  = 12'h008;
  localparam logic [11:0] ALUE = 12'h004, SUBT = 12'h002, OUTL = 12'h001;

  logic [11:0] ctrl_s;
  assign ctrl_s = {pc_enable, pc_inc, mar_load, ram_enable, ir_load, ir_enable,
                   reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract, out_load};

  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int errors = 0;
  int checks = 0;

  // Reference model: instruction step 0..5, halt flag, pending done pulse.
  int m_t = 0;
  bit m_halted = 1'b0;
  bit m_done = 1'b0;

  function automatic logic [11:0] word(input int t, input logic [3:0] op);
    logic [11:0] w;
    w = 12'h000;
    case (t)
      0: w = PCE | MARL;
      1: w = PCI;
      2: w = RAME | IRL;
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = IRE | MARL;
        else if (op == 4'hE) w = RAE | OUTL;
        else w = 12'h000;
      end
      4: begin
        if (op == 4'h0) w = RAME | RAL;
        else if (op == 4'h1 || op == 4'h2) w = RAME | RBL;
        else w = 12'h000;
      end
      5: begin
        if (op == 4'h1) w = ALUE | RAL;
        else if (op == 4'h2) w = ALUE | RAL | SUBT;
        else w = 12'h000;
      end
      default: w = 12'h000;
    endcase
    return w;
  endfunction

  function automatic logic [5:0] onehot(input int t);
    logic [5:0] o;
    o = 6'd0;
    o[t] = 1'b1;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ctrl", {20'd0, ctrl_s}, {20'd0, mon_e[19:8]});
      chk("t_state", {26'd0, t_state}, {26'd0, mon_e[7:2]});
      chk("instr_done", {31'd0, instr_done}, {31'd0, mon_e[1]});
      chk("halted", {31'd0, halted}, {31'd0, mon_e[0]});
      chk("one_driver",
          {31'd0, ($countones({pc_enable, ram_enable, ir_enable, reg_a_enable, alu_enable}) <= 1)},
          32'd1);
    end
  end

  // Drive one cycle, queue what the spec says must appear, then step the model.
  task automatic cyc(input logic r, input logic s, input logic [3:0] op, input logic rst);
    logic adv;
    reset  = rst;
    run    = r;
    step   = s;
    opcode = op;
    if (!rst) begin
      m_t = 0;
      m_halted = 1'b0;
      m_done = 1'b0;
    end
    adv = (r || s) && !m_halted && rst;
    exp_q.push_back({adv ? word(m_t, op) : 12'h000, onehot(m_t), m_done, m_halted});
    @(posedge clk);
    if (adv) begin
      m_done = (m_t == 5);
      if (m_t == 3 && op == 4'hF) m_halted = 1'b1;
      else m_t = (m_t + 1) % 6;
    end else begin
      m_done = 1'b0;
    end
    #1;
  endtask

  logic [3:0] cur_op;
  logic [3:0] op_tbl [0:9];

  initial begin
    reset = 1'b0; run = 1'b1; step = 1'b0; opcode = 4'h1;
    op_tbl[0] = 4'h0; op_tbl[1] = 4'h1; op_tbl[2] = 4'h2; op_tbl[3] = 4'hE;
    op_tbl[4] = 4'h7; op_tbl[5] = 4'h0; op_tbl[6] = 4'h1; op_tbl[7] = 4'h2;
    op_tbl[8] = 4'hE; op_tbl[9] = 4'hF;
    @(posedge clk);
    #1;

    // Reset held with run high, then ADD and SUB free-running.
    repeat (2) cyc(1'b1, 1'b0, 4'h1, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 4'h1, 1'b1);
    chk("add_done_t1", {25'd0, instr_done, t_state}, 32'h41);
    repeat (6) cyc(1'b1, 1'b0, 4'h2, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 4'hE, 1'b1);

    // Single-step LDA: three pulses land on T4.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 4'h0, 1'b1);
      repeat (4) cyc(1'b0, 1'b0, 4'h0, 1'b1);
    end
    chk("step_t4", {26'd0, t_state}, 32'h08);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 4'h0, 1'b1);
      repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b1);
    end

    // HLT freezes at T4; only reset clears it.
    repeat (24) cyc(1'b1, 1'b0, 4'hF, 1'b1);
    chk("halt_hold", {25'd0, halted, t_state}, 32'h48);
    cyc(1'b1, 1'b0, 4'hF, 1'b0);
    chk("halt_cleared", {31'd0, halted}, 32'd0);

    // Reset mid-LDA at T5, then an undefined opcode.
    repeat (4) cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 4'h7, 1'b1);

    // Randomized run/step/reset traffic; opcode only changes before T4.
    cur_op = 4'h0;
    for (int i = 0; i < 800; i++) begin
      if (m_t < 3) begin
        if ($urandom_range(0, 9) == 0) cur_op = 4'($urandom_range(0, 15));
        else cur_op = op_tbl[$urandom_range(0, 9)];
      end
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), cur_op,
          ($urandom_range(0, 59) != 0));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
